sine_cmd_ctrl: RTL
==================

# sine_cmd_ctrl

UART command controller that configures the sine-PWM generator at run time. It parses ASCII commands from the UART receiver byte stream and accumulates decimal period values. Each accepted value is applied to the generator's per-step divider only at a LUT wrap boundary, so no sine period is glitched. A one-byte acknowledge is returned through the UART transmitter handshake.

## Interface
Parameters:
- DIV_W, 16, width of divider value
- DIV_DEFAULT, 1600, divider after reset
- DIV_MIN, 64, smallest accepted divider
- DIV_MAX, 50000, largest accepted divider
- APPLY_TIMEOUT, 2500000, cycles to wait for wrap before forced apply

Ports:
- clk1  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_busy  in  1  UART transmitter busy
- tx_data  out  8  response byte
- tx_en  out  1  one-cycle transmit request
- lut_wrap  in  1  one-cycle pulse from generator when LUT address returns to 0
- div_out  out  DIV_W  divider consumed by generator
- div_load  out  1  one-cycle pulse, div_out changed this cycle
- pwm_en  out  1  generator run enable
- cmd_err  out  1  one-cycle pulse on any rejected command or dropped byte

## Operation
- Commands (case-sensitive): 'F' d{1..5} terminator, sets divider. 'S' terminator clears pwm_en. 'G' terminator sets pwm_en. The terminator is CR (0x0D) or LF (0x0A).
- Response: 'K' (0x4B) on accept, 'E' (0x45) on reject.
- FSM states: IDLE, NUM, APPLY, RESP.
- IDLE, on rx_valid:
  - 'F' clears acc and digit count, then goes to NUM.
  - 'S' or 'G' latches the op and goes to NUM, which then expects only a terminator.
  - A terminator alone is ignored.
  - Any other byte pulses cmd_err and stays in IDLE, with no response.
- NUM:
  - A digit updates acc = acc*10 + (byte-0x30). acc is 17 bits wide and saturates at 0x1FFFF.
  - A sixth digit, a non-digit, or a terminator arriving with zero digits after 'F' rejects the command.
  - A terminator after an 'F' with digits: if acc is within [DIV_MIN, DIV_MAX], go to APPLY; otherwise reject.
  - A terminator after 'S'/'G': update pwm_en, then go to RESP with 'K'.
  - On reject: pulse cmd_err and go to RESP with 'E'.
- APPLY:
  - If pwm_en=0, apply immediately.
  - Otherwise wait for lut_wrap, or for the timeout counter to reach APPLY_TIMEOUT-1, then apply.
  - Apply means div_out <= acc[DIV_W-1:0] and div_load pulses, then go to RESP with 'K'.
- RESP: when tx_busy=0, drive tx_data and a one-cycle tx_en, then return to IDLE.
- rx_valid arriving in APPLY or RESP: the byte is dropped and cmd_err pulses. The state is unaffected.

## Timing
- Reset values: div_out=DIV_DEFAULT, div_load=0, pwm_en=1, tx_en=0, tx_data=0x00, cmd_err=0, state IDLE, acc=0, timeout counter=0.
- All outputs are registered.
- Latency, APPLY with lut_wrap: lut_wrap sampled high at cycle N gives div_out/div_load at cycle N+1.
- Latency, APPLY with pwm_en=0: the terminator accepted at cycle N gives div_load at N+1.
- Latency, RESP: with tx_busy low, tx_en follows one cycle after entering RESP. tx_en never asserts while tx_busy=1.
- lut_wrap outside APPLY is ignored.
- lut_wrap and timeout expiring in the same cycle cause a single apply.
- The timeout counter clears on APPLY entry.
- rst asserted mid-command: everything returns to reset values on the next edge, including div_out=DIV_DEFAULT. Any pending apply and response are discarded.

## Structure
- Package sine_cmd_pkg holds:
  - ASCII constants: CH_F, CH_S, CH_G, CH_CR, CH_LF, CH_0, CH_9, CH_ACK, CH_NAK.
  - The state enum.
  - The 17-bit acc width constant.
- Sub-module ascii_dec_accum holds the digit check, the multiply-by-10 saturating accumulator, and the digit counter. Its controls are clear and step, and its outputs are value, count and is_digit.
- The FSM, timeout counter and output registers live in sine_cmd_ctrl.

## Test plan
- Reset check: after reset, div_out=1600 and pwm_en=1.
- Bytes "F825\r" then lut_wrap 10 cycles later: div_out=825 and div_load pulse exactly one cycle after lut_wrap. tx_data=0x4B with one tx_en.
- "F99999\n": reject with cmd_err and 'E', div_out unchanged. Same for "F123456\r" and "F\r".
- "S\r", then "F300\r" with no lut_wrap: div_out=300 one cycle after the terminator and pwm_en=0. Then "G\r" gives pwm_en=1; each command responds 'K'.
- "F500\r" with pwm_en=1, no lut_wrap, APPLY_TIMEOUT set to 100: div_load occurs 100 cycles after APPLY entry. With tx_busy held high for 50 cycles, tx_en asserts the cycle after tx_busy falls.
- Mid-command reset: "F12" then rst gives all reset values, and a subsequent "4\r" pulses cmd_err with no response.

Source files
------------

// File: rtl/sine_cmd_pkg.sv
// Shared constants and types for the UART command controller of the sine-PWM generator.
package sine_cmd_pkg;

  // Decimal accumulator width: holds five digits (99999) plus saturation headroom.
  localparam int ACC_W = 17;
  localparam logic [ACC_W-1:0] ACC_SAT = '1;

  // ASCII codes recognised by the parser
  localparam logic [7:0] CH_F   = 8'h46;
  localparam logic [7:0] CH_S   = 8'h53;
  localparam logic [7:0] CH_G   = 8'h47;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_ACK = 8'h4B;
  localparam logic [7:0] CH_NAK = 8'h45;

  typedef enum logic [1:0] {ST_IDLE, ST_NUM, ST_APPLY, ST_RESP} state_t;
  typedef enum logic [1:0] {OP_F, OP_S, OP_G} op_t;

  function automatic logic is_term(input logic [7:0] b);
    return (b == CH_CR) || (b == CH_LF);
  endfunction

endpackage

// File: rtl/ascii_dec_accum.sv
// ASCII decimal digit accumulator: value = value*10 + digit, saturating, with digit count.
module ascii_dec_accum
  import sine_cmd_pkg::*;
(
  input  logic             clk1,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  input  logic [7:0]       din,
  output logic [ACC_W-1:0] value,
  output logic [2:0]       count,
  output logic             is_digit
);

  // Wide enough that 0x1FFFF*10 + 9 cannot overflow before the saturation test
  logic [ACC_W+3:0] next_val;

  assign is_digit = (din >= CH_0) && (din <= CH_9);
  // Digits 0x30..0x39 carry their value in the low nibble
  assign next_val = {4'b0, value} * (ACC_W+4)'(10) + {{(ACC_W){1'b0}}, din[3:0]};

  // Accumulate one digit per step; count sticks at 7 so it can never wrap back to a legal value
  always_ff @(posedge clk1) begin
    if (rst || clear) begin
      value <= '0;
      count <= '0;
    end else if (step && is_digit) begin
      value <= (next_val > {4'b0, ACC_SAT}) ? ACC_SAT : next_val[ACC_W-1:0];
      if (count != 3'd7) count <= count + 3'd1;
    end
  end

endmodule

// File: rtl/sine_cmd_ctrl.sv
// Command parser for the sine-PWM generator: decodes F/S/G commands from the UART byte
// stream, defers divider updates to a LUT wrap (or timeout) and answers with 'K' or 'E'.
module sine_cmd_ctrl
  import sine_cmd_pkg::*;
#(
  parameter int DIV_W         = 16,
  parameter int DIV_DEFAULT   = 1600,
  parameter int DIV_MIN       = 64,
  parameter int DIV_MAX       = 50000,
  parameter int APPLY_TIMEOUT = 2500000
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             tx_en,
  input  logic             lut_wrap,
  output logic [DIV_W-1:0] div_out,
  output logic             div_load,
  output logic             pwm_en,
  output logic             cmd_err
);

  localparam int TMO_W = (APPLY_TIMEOUT > 2) ? $clog2(APPLY_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(APPLY_TIMEOUT - 1);

  state_t           state;
  op_t              op;
  logic [7:0]       resp;
  logic [TMO_W-1:0] tmo;

  logic [ACC_W-1:0] acc;
  logic [2:0]       dig_cnt;
  logic             is_digit;
  logic             acc_clear;
  logic             acc_step;
  logic             rx_term;
  logic             in_range;

  assign rx_term   = is_term(rx_data);
  assign in_range  = (acc >= ACC_W'(DIV_MIN)) && (acc <= ACC_W'(DIV_MAX));
  assign acc_clear = (state == ST_IDLE) && rx_valid && (rx_data == CH_F);
  // A sixth digit is not stepped in; the FSM rejects it instead
  assign acc_step  = (state == ST_NUM) && rx_valid && (op == OP_F) && (dig_cnt < 3'd5);

  ascii_dec_accum u_accum (
    .clk1     (clk1),
    .rst      (rst),
    .clear    (acc_clear),
    .step     (acc_step),
    .din      (rx_data),
    .value    (acc),
    .count    (dig_cnt),
    .is_digit (is_digit)
  );

  // Command FSM with timeout counter and all registered outputs
  always_ff @(posedge clk1) begin
    if (rst) begin
      state    <= ST_IDLE;
      op       <= OP_F;
      resp     <= 8'h00;
      tmo      <= '0;
      div_out  <= DIV_W'(DIV_DEFAULT);
      div_load <= 1'b0;
      pwm_en   <= 1'b1;
      tx_data  <= 8'h00;
      tx_en    <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      div_load <= 1'b0;
      tx_en    <= 1'b0;
      cmd_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            if (rx_data == CH_F) begin
              op    <= OP_F;
              state <= ST_NUM;
            end else if (rx_data == CH_S) begin
              op    <= OP_S;
              state <= ST_NUM;
            end else if (rx_data == CH_G) begin
              op    <= OP_G;
              state <= ST_NUM;
            end else if (!rx_term) begin
              // Stray byte between commands: flag it but stay silent
              cmd_err <= 1'b1;
            end
          end
        end
        ST_NUM: begin
          if (rx_valid) begin
            if (acc_step && is_digit) begin
              // digit absorbed by the accumulator
            end else if (rx_term && (op == OP_S)) begin
              pwm_en <= 1'b0;
              resp   <= CH_ACK;
              state  <= ST_RESP;
            end else if (rx_term && (op == OP_G)) begin
              pwm_en <= 1'b1;
              resp   <= CH_ACK;
              state  <= ST_RESP;
            end else if (rx_term && (op == OP_F) && (dig_cnt != 3'd0) && in_range) begin
              if (!pwm_en) begin
                // Generator stopped: no period to protect, load right away
                div_out  <= acc[DIV_W-1:0];
                div_load <= 1'b1;
                resp     <= CH_ACK;
                state    <= ST_RESP;
              end else begin
                tmo   <= '0;
                state <= ST_APPLY;
              end
            end else begin
              cmd_err <= 1'b1;
              resp    <= CH_NAK;
              state   <= ST_RESP;
            end
          end
        end
        ST_APPLY: begin
          if (rx_valid) cmd_err <= 1'b1;
          if (!pwm_en || lut_wrap || (tmo == TMO_LAST)) begin
            div_out  <= acc[DIV_W-1:0];
            div_load <= 1'b1;
            resp     <= CH_ACK;
            state    <= ST_RESP;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        ST_RESP: begin
          if (rx_valid) cmd_err <= 1'b1;
          if (!tx_busy) begin
            tx_data <= resp;
            tx_en   <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
